serial_tx_buffer: RTL and testbench

SERIAL_TX_BUFFER -- requirements
Module: serial_tx_buffer

---
 rtl/serial_tx_buffer_pkg.sv | 20 ++
 rtl/serial_tx_buffer_fifo.sv | 59 +++++
 rtl/serial_tx_buffer.sv | 166 ++++++++++++++++
 tb/tb_serial_tx_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_tx_buffer_pkg.sv
// Shared IO unit types for the serial transmit path: byte type, default FIFO
// depth and the transmitter state encoding.
// Optional feature macro: SERIAL_TX_PARITY_EN adds the PARITY state.
package IO_UnitTypes;

    typedef logic [7:0] SerialDataPath;

    localparam int SERIAL_TX_FIFO_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef SERIAL_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_t;

endpackage

// File: rtl/serial_tx_buffer_fifo.sv
// Byte FIFO for the serial transmitter. Power-of-two depth, so the pointers
// wrap on their own. A push into a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is ignored (the caller flags it).
module serial_tx_fifo
    import IO_UnitTypes::*;
#(
    parameter int DEPTH = SERIAL_TX_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  SerialDataPath             wdata,
    output SerialDataPath             rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    SerialDataPath   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;
    logic            pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= wdata;
    end

    // Pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/serial_tx_buffer.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/stop framer.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1 instead of 8N1).
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line high, waiting for the FIFO to hold a byte
// ST_START  | start bit (low) for CLK_DIV cycles
// ST_DATA   | 8 data bits, LSB first, CLK_DIV cycles each
// ST_PARITY | even parity of the data byte (parity build only)
// ST_STOP   | stop bit (high); chains straight into the next frame if queued
module serial_tx_buffer
    import IO_UnitTypes::*;
#(
    parameter int FIFO_DEPTH = SERIAL_TX_FIFO_DEPTH,
    parameter int CLK_DIV    = 868
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serialWE,
    input  SerialDataPath                 serialWriteData,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
    output logic                          overflow
);
    localparam int            CW     = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    tx_state_t      state;
    tx_state_t      state_nxt;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    SerialDataPath  shift_reg;
    logic           txd_nxt;
    logic           tc;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    SerialDataPath  fifo_rdata;

    serial_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (serialWE),
        .pop   (fifo_pop),
        .wdata (serialWriteData),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifoCount)
    );

    assign tc   = (baud_cnt == '0);
    assign busy = (state != ST_IDLE) || (fifoCount != '0);

`ifdef SERIAL_TX_PARITY_EN
    logic parity_bit;

    // Parity captured at pop time, since the shift register is consumed by DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_bit <= 1'b0;
        else if (fifo_pop)
            parity_bit <= ^fifo_rdata;
    end
`endif

    // Next state, FIFO pop and the next line level (txd is registered).
    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        txd_nxt   = txd;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    state_nxt = ST_START;
                    txd_nxt   = 1'b0;
                end
            end
            ST_START: begin
                if (tc) begin
                    state_nxt = ST_DATA;
                    txd_nxt   = shift_reg[0];
                end
            end
            ST_DATA: begin
                if (tc) begin
                    if (bit_idx == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_nxt = ST_PARITY;
                        txd_nxt   = parity_bit;
`else
                        state_nxt = ST_STOP;
                        txd_nxt   = 1'b1;
`endif
                    end else begin
                        // shift_reg moves right on this edge, so bit 1 is next.
                        txd_nxt = shift_reg[1];
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (tc) begin
                    state_nxt = ST_STOP;
                    txd_nxt   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tc) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        state_nxt = ST_START;
                        txd_nxt   = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                        txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                txd_nxt   = 1'b1;
            end
        endcase
    end

    // State register, baud down-counter, bit index, shift register and line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            txd       <= 1'b1;
        end else begin
            state <= state_nxt;
            txd   <= txd_nxt;
            // Held at reload in IDLE so every bit period starts from CLK_DIV-1.
            if (state == ST_IDLE || tc)
                baud_cnt <= RELOAD;
            else
                baud_cnt <= baud_cnt - 1'b1;
            if (state == ST_DATA && tc)
                bit_idx <= bit_idx + 1'b1;
            if (fifo_pop)
                shift_reg <= fifo_rdata;
            else if (state == ST_DATA && tc)
                shift_reg <= {1'b0, shift_reg[7:1]};
        end
    end

    // Sticky overflow: a write hit a full FIFO with no pop to make room.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (serialWE && fifo_full && !fifo_pop)
            overflow <= 1'b1;
    end

endmodule

// File: tb/tb_serial_tx_buffer.sv
// Bench for serial_tx_buffer with FIFO_DEPTH=4, CLK_DIV=4. A queue-based
// frame model predicts txd/busy/fifoCount/overflow every cycle; directed
// scenarios add literal checks at hand-computed edges.
`timescale 1ns/1ps
module tb_serial_tx_buffer;
    localparam int DEPTH = 4;
    localparam int DIV   = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME = FRAME_BITS * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serialWE = 1'b0;
    logic [7:0] serialWriteData = 8'h00;
    logic       txd;
    logic       busy;
    logic [2:0] fifoCount;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serial_tx_buffer #(
        .FIFO_DEPTH (DEPTH),
        .CLK_DIV    (DIV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .serialWE        (serialWE),
        .serialWriteData (serialWriteData),
        .txd             (txd),
        .busy            (busy),
        .fifoCount       (fifoCount),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // Model: queued bytes, plus position (in cycles) inside the current frame.
    logic [7:0] m_q[$];
    int         m_pos  = -1;
    logic [7:0] m_byte = 8'h00;
    logic       m_ovf  = 1'b0;

    function automatic logic model_txd();
        int b;
        if (m_pos < 0) return 1'b1;
        b = m_pos / DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        if (FRAME_BITS == 11 && b == 9) return ^m_byte;
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_q.delete();
                m_pos = -1;
                m_ovf = 1'b0;
            end else begin
                if (m_pos >= 0) begin
                    m_pos++;
                    if (m_pos == FRAME) m_pos = -1;
                end
                if (m_pos < 0 && m_q.size() != 0) begin
                    m_byte = m_q.pop_front();
                    m_pos  = 0;
                end
                if (serialWE) begin
                    if (m_q.size() < DEPTH) m_q.push_back(serialWriteData);
                    else m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("m_txd", txd, model_txd());
            check("m_busy", busy, (m_pos >= 0 || m_q.size() != 0));
            check("m_fifoCount", fifoCount, m_q.size());
            check("m_overflow", overflow, m_ovf);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Present one byte at the next edge; returns at the negedge after it.
    task automatic send(input logic [7:0] d);
        serialWE = 1'b1;
        serialWriteData = d;
        tick(1);
        serialWE = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (busy && n < 2000) begin
            tick(1);
            n++;
        end
        check("drain_timeout", n < 2000, 1);
        tick(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Writes during reset must be ignored.
        rst = 1'b1;
        serialWE = 1'b1;
        serialWriteData = 8'hEE;
        tick(3);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        check("rst_count", fifoCount, 0);
        check("rst_ovf", overflow, 0);
        serialWE = 1'b0;
        rst = 1'b0;
        tick(2);
        check("post_rst_busy", busy, 0);

        // 0x55 single frame, edge-exact timing.
        send(8'h55);
        check("e0_txd_idle", txd, 1);
        check("e0_count", fifoCount, 1);
        check("e0_busy", busy, 1);
        tick(1);
        check("e1_start", txd, 0);
        check("e1_count", fifoCount, 0);
        tick(4);
        check("e5_bit0", txd, 1);
        tick(4);
        check("e9_bit1", txd, 0);
        tick(FRAME - 12);
        check("stop_high", txd, 1);
        tick(3);
        check("last_stop_busy", busy, 1);
        tick(1);
        check("end_busy", busy, 0);
        tick(3);

        // 0xA5, 0x3C back-to-back.
        send(8'hA5);
        send(8'h3C);
        check("b2b_count_e1", fifoCount, 1);
        check("b2b_start_e1", txd, 0);
        tick(FRAME - 1);
        check("b2b_stop", txd, 1);
        tick(1);
        check("b2b_restart", txd, 0);
        check("b2b_count_after", fifoCount, 0);
        check("b2b_busy", busy, 1);
        drain();

        // Fill the FIFO, then write on the exact cycle a pop frees a slot.
        send(8'h10);
        send(8'h11);
        send(8'h12);
        send(8'h13);
        send(8'h14);
        check("full_count", fifoCount, 4);
        tick(FRAME - 4);
        serialWE = 1'b1;
        serialWriteData = 8'h77;
        tick(1);
        serialWE = 1'b0;
        check("pushpop_count", fifoCount, 4);
        check("pushpop_ovf", overflow, 0);
        check("pushpop_start", txd, 0);
        drain();

        // Six writes into a depth-4 FIFO: the sixth is dropped.
        for (int i = 1; i <= 6; i++) send(8'(i));
        check("ovf_count", fifoCount, 4);
        check("ovf_set", overflow, 1);
        drain();
        check("ovf_sticky", overflow, 1);

`ifdef SERIAL_TX_PARITY_EN
        // 0x07: bit7 = 0, then parity 1 for DIV cycles before STOP.
        send(8'h07);
        tick(33);
        check("par_bit7", txd, 0);
        tick(4);
        check("par_bit", txd, 1);
        tick(3);
        check("par_bit_end", txd, 1);
        drain();
`endif

        // Reset clears overflow; then abort a 0xFF frame in data bit 3.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst2_ovf", overflow, 0);
        tick(1);
        send(8'hFF);
        send(8'h12);
        tick(17);
        check("pre_abort_txd", txd, 1);
        check("pre_abort_count", fifoCount, 1);
        check("pre_abort_busy", busy, 1);
        rst = 1'b1;
        serialWE = 1'b1;
        serialWriteData = 8'h99;
        #1;
        check("abort_txd", txd, 1);
        check("abort_count", fifoCount, 0);
        check("abort_busy", busy, 0);
        tick(3);
        serialWE = 1'b0;
        rst = 1'b0;
        tick(60);
        check("after_abort_txd", txd, 1);
        check("after_abort_busy", busy, 0);
        check("after_abort_count", fifoCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
